// File: rtl/nm_adc_sample_fifo.sv
// Synchronous sample FIFO between one NM ADC readout channel and the PDMA packer.
// Occupancy is tracked only by the registered level counter. The pointers wrap
// freely modulo DEPTH. Overflow and underflow are single-cycle registered pulses.
module nm_adc_sample_fifo #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 6,
    parameter int AFULL_LVL = 48
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   level,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_L   = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic empty_w, full_w;
    logic rd_accept, wr_accept;

    // Flags come straight from the registered level, so they lag the accept by one cycle.
    assign empty_w = (level_q == '0);
    assign full_w  = (level_q == DEPTH_L);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_accept = ena & rd_en & ~empty_w;
    assign wr_accept = ena & wr_en & (~full_w | rd_accept);

    // Next-state: pointers, level, read port and violation pulses; ena low flushes.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (!ena) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            if (wr_accept && !rd_accept) begin
                level_d = level_q + LVL_ONE;
            end else if (rd_accept && !wr_accept) begin
                level_d = level_q - LVL_ONE;
            end
            overflow_d  = wr_en & ~wr_accept;
            underflow_d = rd_en & empty_w;
        end
    end

    // Control and read-port registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Sample storage is not reset; stale words are never readable because level gates reads.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign level       = level_q;
    assign empty       = empty_w;
    assign full        = full_w;
    assign almost_full = (level_q >= AFULL_L);
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_nm_adc_sample_fifo.sv
// Directed testbench for nm_adc_sample_fifo.
module tb_nm_adc_sample_fifo;

    logic        clk;
    logic        rstb;
    logic        ena;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [6:0]  level;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    nm_adc_sample_fifo #(.DATA_W(16), .ADDR_W(6), .AFULL_LVL(48)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Write n words base, base+1, ... on consecutive cycles.
    task automatic push_n(input int n, input logic [15:0] base);
        wr_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            wr_data = 16'(base + 16'(i));
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (level !== 7'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: level=%0d empty=%b full=%b afull=%b, want 0 1 0 0",
                     level, empty, full, almost_full);
        end
        checks++;
        if (rd_data !== 16'h0000 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: rd_data=%h rd_valid=%b ovf=%b udf=%b, want 0000 0 0 0",
                     rd_data, rd_valid, overflow, underflow);
        end
        step();
        step();
        rstb = 1'b1;
        ena  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            checks++;
            if (empty !== 1'b1 || level !== 7'd0) begin
                errors++;
                $display("FAIL idle_empty cycle %0d: empty=%b level=%0d, want 1 0", c, empty, level);
            end
        end
    endtask

    task automatic test_fill_drain;
        wr_en = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            wr_data = 16'(i);
            step();
            checks++;
            if (level !== 7'(i) || almost_full !== (i >= 48) || full !== (i == 64)) begin
                errors++;
                $display("FAIL fill_level %0d: level=%0d afull=%b full=%b, want %0d %b %b",
                         i, level, almost_full, full, i, (i >= 48), (i == 64));
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 16'(k)) begin
                errors++;
                $display("FAIL drain_data %0d: valid=%b data=%h, want 1 %h", k, rd_valid, rd_data, 16'(k));
            end
        end
        rd_en = 1'b0;
        step();
        checks++;
        if (rd_valid !== 1'b0 || empty !== 1'b1 || level !== 7'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: valid=%b empty=%b level=%0d udf=%b, want 0 1 0 0",
                     rd_valid, empty, level, underflow);
        end
    endtask

    task automatic test_overflow;
        push_n(64, 16'h0100);
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_prefill: full=%b ovf=%b, want 1 0", full, overflow);
        end
        wr_en   = 1'b1;
        wr_data = 16'hBEEF;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (overflow !== 1'b1 || level !== 7'd64) begin
                errors++;
                $display("FAIL ovf_pulse %0d: ovf=%b level=%0d, want 1 64", c, overflow, level);
            end
        end
        wr_en = 1'b0;
        step();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, want 0", overflow);
        end
        rd_en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 16'(16'h0100 + 16'(k))) begin
                errors++;
                $display("FAIL ovf_read %0d: valid=%b data=%h, want 1 %h",
                         k, rd_valid, rd_data, 16'(16'h0100 + 16'(k)));
            end
        end
        rd_en = 1'b0;
        step();
        checks++;
        if (empty !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_end: empty=%b valid=%b, want 1 0", empty, rd_valid);
        end
    endtask

    task automatic test_underflow;
        rd_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 16'h013F) begin
                errors++;
                $display("FAIL udf_pulse %0d: udf=%b valid=%b data=%h, want 1 0 013f",
                         c, underflow, rd_valid, rd_data);
            end
        end
        wr_en   = 1'b1;
        wr_data = 16'h1234;
        step();
        checks++;
        if (underflow !== 1'b1 || level !== 7'd1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL udf_wr_rd: udf=%b level=%0d valid=%b, want 1 1 0", underflow, level, rd_valid);
        end
        wr_en = 1'b0;
        step();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1234 || underflow !== 1'b0 || level !== 7'd0) begin
            errors++;
            $display("FAIL udf_readback: valid=%b data=%h udf=%b level=%0d, want 1 1234 0 0",
                     rd_valid, rd_data, underflow, level);
        end
        rd_en = 1'b0;
        step();
        checks++;
        if (empty !== 1'b1 || underflow !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL udf_end: empty=%b udf=%b valid=%b, want 1 0 0", empty, underflow, rd_valid);
        end
    endtask

    task automatic test_back_to_back;
        push_n(64, 16'h2000);
        wr_en = 1'b1;
        rd_en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            wr_data = 16'(16'h2040 + 16'(c));
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 16'(16'h2000 + 16'(c)) || level !== 7'd64 ||
                overflow !== 1'b0) begin
                errors++;
                $display("FAIL b2b %0d: valid=%b data=%h level=%0d ovf=%b, want 1 %h 64 0",
                         c, rd_valid, rd_data, level, overflow, 16'(16'h2000 + 16'(c)));
            end
        end
        wr_en = 1'b0;
        for (int k = 0; k < 64; k++) begin
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 16'(16'h20C8 + 16'(k))) begin
                errors++;
                $display("FAIL b2b_drain %0d: valid=%b data=%h, want 1 %h",
                         k, rd_valid, rd_data, 16'(16'h20C8 + 16'(k)));
            end
        end
        rd_en = 1'b0;
        step();
        checks++;
        if (empty !== 1'b1 || level !== 7'd0) begin
            errors++;
            $display("FAIL b2b_end: empty=%b level=%0d, want 1 0", empty, level);
        end
    endtask

    task automatic test_flush_reset;
        push_n(11, 16'h3000);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 16'h3000 || level !== 7'd10) begin
            errors++;
            $display("FAIL flush_pre: data=%h level=%0d, want 3000 10", rd_data, level);
        end
        ena     = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 16'hDEAD;
        step();
        checks++;
        if (level !== 7'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
            rd_valid !== 1'b0 || rd_data !== 16'h3000) begin
            errors++;
            $display("FAIL ena_flush: level=%0d empty=%b ovf=%b udf=%b valid=%b data=%h, want 0 1 0 0 0 3000",
                     level, empty, overflow, underflow, rd_valid, rd_data);
        end
        ena     = 1'b1;
        rd_en   = 1'b0;
        wr_data = 16'h5A5A;
        step();
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h5A5A || level !== 7'd0) begin
            errors++;
            $display("FAIL ena_after: valid=%b data=%h level=%0d, want 1 5a5a 0", rd_valid, rd_data, level);
        end

        push_n(10, 16'h4000);
        wr_en   = 1'b1;
        wr_data = 16'h4444;
        step();
        #2;
        rstb = 1'b0;
        #1;
        checks++;
        if (level !== 7'd0 || empty !== 1'b1 || full !== 1'b0 || rd_data !== 16'h0000 ||
            rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: level=%0d empty=%b full=%b data=%h valid=%b ovf=%b udf=%b, want 0 1 0 0000 0 0 0",
                     level, empty, full, rd_data, rd_valid, overflow, underflow);
        end
        wr_en = 1'b0;
        rstb  = 1'b1;
        step();
        checks++;
        if (level !== 7'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: level=%0d ovf=%b udf=%b, want 0 0 0", level, overflow, underflow);
        end
        wr_en   = 1'b1;
        wr_data = 16'hA5A5;
        step();
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_after: valid=%b data=%h empty=%b, want 1 a5a5 1", rd_valid, rd_data, empty);
        end
    endtask

    initial begin
        rstb    = 1'b0;
        ena     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 16'h0000;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
